// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the timing generator to the
// pixel colour stage and the VGA connector.
//   h_cnt/v_cnt  scan position (10 bits each)
//   valid        active video region
//   hsync/vsync  connector sync levels
//   pix_tick     one-clk pulse when a new position is presented
//   line_start   one-clk pulse when h_cnt becomes 0
//   frame_start  one-clk pulse when (h_cnt,v_cnt) becomes (0,0)
interface vga_timing_gen_if;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       valid;
  logic       hsync;
  logic       vsync;
  logic       pix_tick;
  logic       line_start;
  logic       frame_start;

  modport master (
    output h_cnt, v_cnt, valid, hsync, vsync, pix_tick, line_start, frame_start
  );
  modport slave (
    input  h_cnt, v_cnt, valid, hsync, vsync, pix_tick, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator with an internal pixel
// clock-enable divider (CLK_DIV system clocks per pixel).
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-high
//   vga  timing bundle (master side): position, valid, syncs, strobes
// Every output is a flop; the decoded outputs are computed from the next
// position so they change on the same edge as the counters.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_DISP   = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_DISP   = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_ACT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  vga
);
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_DISP + H_FP;
  localparam int HS_END  = H_DISP + H_FP + H_SYNC;
  localparam int VS_BEG  = V_DISP + V_FP;
  localparam int VS_END  = V_DISP + V_FP + V_SYNC;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1 || CLK_DIV > 16) begin : g_param_err
      $error("vga_timing_gen: illegal geometry or CLK_DIV");
    end
  endgenerate

  logic [DIV_W-1:0] div;
  logic             adv;
  logic [9:0]       h_q, v_q, h_nxt, v_nxt;
  logic             h_wrap;
  logic             valid_q, hsync_q, vsync_q;
  logic             pix_q, line_q, frame_q;

  // With CLK_DIV=1 div is stuck at 0 and the compare is always true.
  assign adv    = (div == DIV_W'(CLK_DIV - 1));
  assign h_wrap = (h_q == 10'(H_TOTAL - 1));

  always_comb begin
    h_nxt = h_wrap ? 10'd0 : h_q + 10'd1;
    v_nxt = v_q;
    if (h_wrap) v_nxt = (v_q == 10'(V_TOTAL - 1)) ? 10'd0 : v_q + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      h_q     <= 10'(H_TOTAL - 1);
      v_q     <= 10'(V_TOTAL - 1);
      valid_q <= 1'b0;
      hsync_q <= ~SYNC_ACT;
      vsync_q <= ~SYNC_ACT;
      pix_q   <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      div <= adv ? '0 : div + 1'b1;
      if (adv) begin
        h_q     <= h_nxt;
        v_q     <= v_nxt;
        valid_q <= ({1'b0, h_nxt} < 11'(H_DISP)) && ({1'b0, v_nxt} < 11'(V_DISP));
        // 11-bit compares so an end bound of 1024 does not alias to 0.
        hsync_q <= ({1'b0, h_nxt} >= 11'(HS_BEG) && {1'b0, h_nxt} < 11'(HS_END))
                   ? SYNC_ACT : ~SYNC_ACT;
        vsync_q <= ({1'b0, v_nxt} >= 11'(VS_BEG) && {1'b0, v_nxt} < 11'(VS_END))
                   ? SYNC_ACT : ~SYNC_ACT;
        pix_q   <= 1'b1;
        line_q  <= (h_nxt == 10'd0);
        frame_q <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
      end else begin
        pix_q   <= 1'b0;
        line_q  <= 1'b0;
        frame_q <= 1'b0;
      end
    end
  end

  assign vga.h_cnt       = h_q;
  assign vga.v_cnt       = v_q;
  assign vga.valid       = valid_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.pix_tick    = pix_q;
  assign vga.line_start  = line_q;
  assign vga.frame_start = frame_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480 /4, a tiny
// 15x8 raster /3 with active-high sync, the same tiny raster /1).
// Expected outputs come from a closed-form model indexed by edges since
// reset release, queued at each posedge and compared at the negedge,
// plus a constant vector table and hand sequences for the corner cases.
module tb_vga_timing_gen;
  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic vl, hs, vs, pt, ls, fs;
  } obs_t;

  typedef struct {
    int cdiv, hd, hf, hsw, hb, vd, vf, vsw, vb;
    bit act;
  } geo_t;

  typedef struct {
    int   k;
    obs_t e;
  } vec_t;

  localparam geo_t GA = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
  localparam geo_t GB = '{3, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1};
  localparam geo_t GC = '{1, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0};

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   n_cmp = 0, n_err = 0;
  int   ka = 0, kb = 0, kc = 0, cyc = 0;
  bit   sb_en = 1'b0;
  obs_t qa[$], qb[$], qc[$];

  always #5 clk = ~clk;

  vga_timing_gen_if ifa();
  vga_timing_gen_if ifb();
  vga_timing_gen_if ifc();

  vga_timing_gen dut_a (.clk(clk), .rst(rst_a), .vga(ifa));

  vga_timing_gen #(.CLK_DIV(3), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACT(1'b1))
    dut_b (.clk(clk), .rst(rst_b), .vga(ifb));

  vga_timing_gen #(.CLK_DIV(1), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACT(1'b0))
    dut_c (.clk(clk), .rst(rst_c), .vga(ifc));

  // k = rising edges since reset was released (0 while in reset).
  function automatic obs_t model(int k, geo_t g);
    obs_t o;
    int ht, vt, a, p, h, v;
    ht = g.hd + g.hf + g.hsw + g.hb;
    vt = g.vd + g.vf + g.vsw + g.vb;
    a  = k / g.cdiv;
    if (a == 0) begin
      o = {10'(ht - 1), 10'(vt - 1), 1'b0, ~g.act, ~g.act, 1'b0, 1'b0, 1'b0};
      return o;
    end
    p = a - 1;
    h = p % ht;
    v = (p / ht) % vt;
    o.h  = 10'(h);
    o.v  = 10'(v);
    o.vl = (h < g.hd) && (v < g.vd);
    o.hs = (h >= g.hd + g.hf && h < g.hd + g.hf + g.hsw) ? g.act : ~g.act;
    o.vs = (v >= g.vd + g.vf && v < g.vd + g.vf + g.vsw) ? g.act : ~g.act;
    o.pt = (k % g.cdiv) == 0;
    o.ls = o.pt && (h == 0);
    o.fs = o.ls && (v == 0);
    return o;
  endfunction

  function automatic obs_t mk(int h, int v, bit vl, bit hs, bit vs, bit pt, bit ls, bit fs);
    return {10'(h), 10'(v), vl, hs, vs, pt, ls, fs};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic obs_t obs_a();
    return {ifa.h_cnt, ifa.v_cnt, ifa.valid, ifa.hsync, ifa.vsync,
            ifa.pix_tick, ifa.line_start, ifa.frame_start};
  endfunction

  // Scoreboard: push at the edge, pop and compare half a cycle later.
  always @(posedge clk) begin
    cyc = cyc + 1;
    ka = rst_a ? 0 : ka + 1;
    kb = rst_b ? 0 : kb + 1;
    kc = rst_c ? 0 : kc + 1;
    qa.push_back(model(ka, GA));
    qb.push_back(model(kb, GB));
    qc.push_back(model(kc, GC));
  end

  always @(negedge clk) begin
    obs_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      if (sb_en) chk("sb_a", 32'(obs_a()), 32'(e));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      if (sb_en) chk("sb_b", 32'({ifb.h_cnt, ifb.v_cnt, ifb.valid, ifb.hsync, ifb.vsync,
                                  ifb.pix_tick, ifb.line_start, ifb.frame_start}), 32'(e));
    end
    if (qc.size() > 0) begin
      e = qc.pop_front();
      if (sb_en) chk("sb_c", 32'({ifc.h_cnt, ifc.v_cnt, ifc.valid, ifc.hsync, ifc.vsync,
                                  ifc.pix_tick, ifc.line_start, ifc.frame_start}), 32'(e));
    end
  end

  // Strobe period checks, restarted by any reset of that instance.
  int last_fb = -1, last_lb = -1, last_fc = -1, last_lc = -1;
  always @(negedge clk) begin
    if (sb_en) begin
      if (rst_b) begin last_fb = -1; last_lb = -1; end
      else begin
        if (ifb.frame_start) begin
          if (last_fb >= 0) chk("frame_period_b", 32'(cyc - last_fb), 32'd360);
          last_fb = cyc;
        end
        if (ifb.line_start) begin
          if (last_lb >= 0) chk("line_period_b", 32'(cyc - last_lb), 32'd45);
          last_lb = cyc;
        end
      end
      if (!rst_c && kc > 0) begin
        chk("pix_tick_c", 32'(ifc.pix_tick), 32'd1);
        if (ifc.frame_start) begin
          if (last_fc >= 0) chk("frame_period_c", 32'(cyc - last_fc), 32'd120);
          last_fc = cyc;
        end
        if (ifc.line_start) begin
          if (last_lc >= 0) chk("line_period_c", 32'(cyc - last_lc), 32'd15);
          last_lc = cyc;
        end
      end
    end
  end

  task automatic wait_ka(int k);
    int guard = 0;
    while (ka != k && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (ka != k) chk("timeout_ka", 32'(ka), 32'(k));
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{3,    mk(799, 524, 0, 1, 1, 0, 0, 0)};
    tbl[1]  = '{4,    mk(0,   0,   1, 1, 1, 1, 1, 1)};
    tbl[2]  = '{5,    mk(0,   0,   1, 1, 1, 0, 0, 0)};
    tbl[3]  = '{8,    mk(1,   0,   1, 1, 1, 1, 0, 0)};
    tbl[4]  = '{2560, mk(639, 0,   1, 1, 1, 1, 0, 0)};
    tbl[5]  = '{2564, mk(640, 0,   0, 1, 1, 1, 0, 0)};
    tbl[6]  = '{2627, mk(655, 0,   0, 1, 1, 0, 0, 0)};
    tbl[7]  = '{2628, mk(656, 0,   0, 0, 1, 1, 0, 0)};
    tbl[8]  = '{3011, mk(751, 0,   0, 0, 1, 0, 0, 0)};
    tbl[9]  = '{3012, mk(752, 0,   0, 1, 1, 1, 0, 0)};
    tbl[10] = '{3200, mk(799, 0,   0, 1, 1, 1, 0, 0)};
    tbl[11] = '{3204, mk(0,   1,   1, 1, 1, 1, 1, 0)};

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (2) @(negedge clk);
    sb_en = 1'b1;
    chk("reset_state_a", 32'(obs_a()), 32'(mk(799, 524, 0, 1, 1, 0, 0, 0)));
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    for (int i = 0; i < 12; i++) begin
      wait_ka(tbl[i].k);
      chk($sformatf("vec%0d_k%0d", i, tbl[i].k), 32'(obs_a()), 32'(tbl[i].e));
    end

    // One-clk reset at (300,1), in the middle of a pixel.
    wait_ka(4405);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    chk("midreset_a", 32'(obs_a()), 32'(mk(799, 524, 0, 1, 1, 0, 0, 0)));
    @(negedge clk);
    rst_b = 1'b0;
    chk("midreset_b_h", 32'(ifb.h_cnt), 32'd14);
    chk("midreset_b_v", 32'(ifb.v_cnt), 32'd7);
    wait_ka(3);
    chk("post_reset_k3_a", 32'(obs_a()), 32'(mk(799, 524, 0, 1, 1, 0, 0, 0)));
    wait_ka(4);
    chk("post_reset_first_a", 32'(obs_a()), 32'(mk(0, 0, 1, 1, 1, 1, 1, 1)));

    wait_ka(1200);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
